reaction_arbiter: RTL

- Multi-player successor to the single-player reaction-timer controller. After `start` it waits a pseudo-random delay, then lights the GO LED and times each player's `stop` press.
- Flags false starts per player, applies a response timeout and reports the first valid responder.
- Sits between the debounced push-button inputs and the counter/7-segment display path. Keeps the existing 2-bit counter-control encoding.

---
 rtl/reaction_pkg.sv | 23 ++
 rtl/rise_detect.sv | 17 +
 rtl/reaction_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared FSM states, counter-control codes and helpers
// for the multi-player reaction arbiter.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        GO,
        DONE
    } state_t;

    localparam logic [1:0] CF_CLEAR = 2'b00;
    localparam logic [1:0] CF_STOP  = 2'b01;
    localparam logic [1:0] CF_RUN   = 2'b10;

    // Galois toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic int wid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of a level input.
// The history flop follows the input every cycle, including during clear.
module rise_detect (
    input  logic clk_50M,
    input  logic din,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk_50M) begin
        hist <= din;
    end

    assign rise = din & ~hist;

endmodule

// File: rtl/reaction_arbiter.sv
// reaction_arbiter: multi-player reaction timer with foul/timeout/winner.
// Define REACT_FIXED_DELAY_EN for a fixed DELAY_MIN delay without the LFSR.
module reaction_arbiter
    import reaction_pkg::*;
#(
    parameter int          NUM_PLAYERS     = 2,
    parameter int          CNT_W           = 32,
    parameter int          DELAY_MIN       = 100000000,
    parameter int          DELAY_SPAN_LOG2 = 28,
    parameter int          TIMEOUT_CYC     = 500000000,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2D5B,
    localparam int         WID_W           = wid_w(NUM_PLAYERS)
) (
    input  logic                         clk_50M,
    input  logic                         clear,
    input  logic                         start,
    input  logic [NUM_PLAYERS-1:0]       stop,
    output logic                         LED,
    output logic [1:0]                   CounterFlag,
    output logic [NUM_PLAYERS-1:0]       foul,
    output logic [NUM_PLAYERS-1:0]       done,
    output logic [NUM_PLAYERS-1:0]       timed_out,
    output logic [NUM_PLAYERS*CNT_W-1:0] react_time,
    output logic [WID_W-1:0]             winner_id,
    output logic                         winner_valid
);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 ||
        64'(TIMEOUT_CYC) >= (64'd1 << CNT_W) ||
        64'(DELAY_MIN) + (64'd1 << DELAY_SPAN_LOG2) >= (64'd1 << CNT_W))
    begin : g_bad_cfg
        $error("reaction_arbiter: invalid player count or counter width");
    end

    state_t                              state, state_n;
    logic [CNT_W-1:0]                    wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0]                    react_cnt, react_cnt_n;
    logic [CNT_W-1:0]                    delay_target, delay_target_n;
    logic [CNT_W-1:0]                    delay_pick;
    logic [NUM_PLAYERS-1:0][CNT_W-1:0]   rt, rt_n;
    logic [NUM_PLAYERS-1:0]              foul_n, done_n, to_n;
    logic [NUM_PLAYERS-1:0]              stop_rise, hit;
    logic [WID_W-1:0]                    wid_n;
    logic [1:0]                          cf_n;
    logic                                led_n, wv_n, start_rise;

    rise_detect u_start_rd (
        .clk_50M (clk_50M),
        .din     (start),
        .rise    (start_rise)
    );

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_stop_rd
        rise_detect u_stop_rd (
            .clk_50M (clk_50M),
            .din     (stop[i]),
            .rise    (stop_rise[i])
        );
    end

`ifdef REACT_FIXED_DELAY_EN
    assign delay_pick = CNT_W'(DELAY_MIN);
`else
    logic [31:0] lfsr;

    always_ff @(posedge clk_50M) begin
        if (clear)
            lfsr <= LFSR_SEED;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
    end

    assign delay_pick = CNT_W'(DELAY_MIN) + CNT_W'(lfsr[DELAY_SPAN_LOG2-1:0]);
`endif

    always_comb begin
        state_n        = state;
        wait_cnt_n     = wait_cnt;
        react_cnt_n    = react_cnt;
        delay_target_n = delay_target;
        rt_n           = rt;
        foul_n         = foul;
        done_n         = done;
        to_n           = timed_out;
        wid_n          = winner_id;
        wv_n           = winner_valid;
        cf_n           = CounterFlag;
        led_n          = LED;
        hit            = '0;
        unique case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_n        = ARMED;
                    delay_target_n = delay_pick;
                    wait_cnt_n     = '0;
                    rt_n           = '0;
                    foul_n         = '0;
                    done_n         = '0;
                    to_n           = '0;
                    wv_n           = 1'b0;
                    cf_n           = CF_CLEAR;
                    led_n          = 1'b0;
                end
            end
            ARMED: begin
                wait_cnt_n = wait_cnt + 1'b1;
                foul_n     = foul | (stop_rise & ~done);
                done_n     = done | stop_rise;
                if (&done_n) begin
                    state_n = DONE;
                    cf_n    = CF_STOP;
                end else if (wait_cnt == delay_target - 1'b1) begin
                    state_n     = GO;
                    led_n       = 1'b1;
                    cf_n        = CF_RUN;
                    react_cnt_n = '0;
                end
            end
            GO: begin
                react_cnt_n = react_cnt + 1'b1;
                hit         = stop_rise & ~done;
                done_n      = done | hit;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (hit[i])
                        rt_n[i] = react_cnt;
                end
                // descending scan leaves the lowest simultaneous index
                if (|hit && !winner_valid) begin
                    wv_n = 1'b1;
                    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
                        if (hit[i])
                            wid_n = WID_W'(i);
                    end
                end
                if (&done_n || react_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n = DONE;
                    led_n   = 1'b0;
                    cf_n    = CF_STOP;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (!done_n[i])
                            rt_n[i] = CNT_W'(TIMEOUT_CYC);
                    end
                    to_n   = ~done_n;
                    done_n = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (clear) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            react_cnt    <= '0;
            delay_target <= '0;
            rt           <= '0;
            foul         <= '0;
            done         <= '0;
            timed_out    <= '0;
            winner_id    <= '0;
            winner_valid <= 1'b0;
            CounterFlag  <= CF_CLEAR;
            LED          <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= wait_cnt_n;
            react_cnt    <= react_cnt_n;
            delay_target <= delay_target_n;
            rt           <= rt_n;
            foul         <= foul_n;
            done         <= done_n;
            timed_out    <= to_n;
            winner_id    <= wid_n;
            winner_valid <= wv_n;
            CounterFlag  <= cf_n;
            LED          <= led_n;
        end
    end

    assign react_time = rt;

endmodule
